dds_iq: RTL and testbench

//  Quadrature DDS/NCO. A phase accumulator feeds a quarter-wave sine LUT and produces

---
 rtl/dds_iq.sv | 180 ++++++++++++++++++
 tb/tb_dds_iq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_iq.sv
// Quadrature DDS/NCO: phase accumulator -> quarter-wave sine LUT -> signed sin/cos, 3-stage pipeline.
// Optional: define DDS_DITHER_EN to add LFSR phase dither below the LUT address LSB.
module dds_iq #(
  parameter int    ASZ         = 11,
  parameter int    LSZ         = 16,
  parameter int    PSZ         = 32,
  parameter int    SYNC_UPDATE = 1,
  parameter string LUT_FILE    = "./common/dds/dds_lut.memh"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PSZ-1:0]        phaseInc,
  input  logic                  inc_load,
  input  logic [PSZ-1:0]        phaseOfs,
  output logic signed [LSZ-1:0] sin,
  output logic signed [LSZ-1:0] cos,
  output logic                  valid,
  output logic                  wrap,
  output logic [1:0]            quadSampleState
);

  localparam int DEPTH = 1 << ASZ;

  // The table is built from the same formula that generates LUT_FILE, so the file is never read;
  // the parameter stays so existing instantiations keep elaborating.
  logic lut_file_unused;
  assign lut_file_unused = (LUT_FILE != "");

  function automatic logic signed [LSZ-1:0] lut_round(input int idx);
    real amp;
    real ang;
    amp = (2.0 ** (LSZ - 1)) - 1.0;
    ang = 3.14159265358979323846 * (real'(idx) + 0.5) / (2.0 ** (ASZ + 1));
    return LSZ'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  function automatic logic signed [LSZ-1:0] apply_sign(input logic signed [LSZ-1:0] mag,
                                                       input logic               neg);
    return neg ? -mag : mag;
  endfunction

  logic signed [LSZ-1:0] lut_rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign lut_rom[i] = lut_round(i);
  end

  // ---- stage 0: tuning registers and phase accumulator
  logic [PSZ-1:0] acc;
  logic [PSZ-1:0] inc_active;
  logic [PSZ-1:0] inc_pending;
  logic           pend_vld;
  logic [PSZ:0]   acc_sum;
  logic           carry;
  logic           xfer;
  logic           vld_p0;
  logic           wrap_p0;

  assign acc_sum = {1'b0, acc} + {1'b0, inc_active};
  assign carry   = acc_sum[PSZ];

  // With inc_active at zero the accumulator can never wrap, so a pending word is taken at once
  // rather than waiting forever; there is no running phase to keep continuous in that case.
  always_comb begin
    xfer = 1'b0;
    if (SYNC_UPDATE != 0)
      xfer = pend_vld && ((en && carry) || (inc_active == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_active  <= '0;
      inc_pending <= '0;
      pend_vld    <= 1'b0;
    end else begin
      if (inc_load)
        inc_pending <= phaseInc;
      if (SYNC_UPDATE != 0) begin
        if (xfer)
          inc_active <= inc_pending;
        if (inc_load)
          pend_vld <= 1'b1;
        else if (xfer)
          pend_vld <= 1'b0;
      end else begin
        if (inc_load)
          inc_active <= phaseInc;
        pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      vld_p0  <= 1'b0;
      wrap_p0 <= 1'b0;
    end else begin
      vld_p0  <= en;
      wrap_p0 <= en & carry;
      if (en)
        acc <= acc_sum[PSZ-1:0];
    end
  end

  logic [1:0]         q_s;
  logic [1:0]         q_c;
  logic [ASZ-1:0]     a;
  logic [ASZ-1:0]     addr_s;
  logic [ASZ-1:0]     addr_c;
  logic [PSZ-ASZ-3:0] trunc_unused;

`ifdef DDS_DITHER_EN
  localparam int DW = (PSZ - ASZ - 2 > 16) ? 16 : (PSZ - ASZ - 2);
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (en)
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign {q_s, a, trunc_unused} = acc + phaseOfs + PSZ'(lfsr[DW-1:0]);
`else
  assign {q_s, a, trunc_unused} = acc + phaseOfs;
`endif

  assign q_c    = q_s + 2'd1;
  assign addr_s = q_s[0] ? ~a : a;
  assign addr_c = q_c[0] ? ~a : a;

  // ---- stage 1: registered LUT reads with sign, quadrant and tags alongside
  logic signed [LSZ-1:0] lut_s_p1;
  logic signed [LSZ-1:0] lut_c_p1;
  logic                  neg_s_p1;
  logic                  neg_c_p1;
  logic [1:0]            q_p1;
  logic                  vld_p1;
  logic                  wrap_p1;

  always_ff @(posedge clk) begin
    lut_s_p1 <= lut_rom[addr_s];
    lut_c_p1 <= lut_rom[addr_c];
    neg_s_p1 <= q_s[1];
    neg_c_p1 <= q_c[1];
    q_p1     <= q_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      wrap_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      wrap_p1 <= wrap_p0;
    end
  end

  // ---- stage 2: sign-applied output registers, held while no new sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      sin             <= '0;
      cos             <= '0;
      valid           <= 1'b0;
      wrap            <= 1'b0;
      quadSampleState <= 2'd0;
    end else begin
      valid <= vld_p1;
      wrap  <= vld_p1 & wrap_p1;
      if (vld_p1) begin
        sin             <= apply_sign(lut_s_p1, neg_s_p1);
        cos             <= apply_sign(lut_c_p1, neg_c_p1);
        quadSampleState <= q_p1;
      end
    end
  end

endmodule

// File: tb/tb_dds_iq.sv
// Scoreboard bench for dds_iq: one instance with immediate tuning update, one with wrap-synchronous update.
module tb_dds_iq;

  logic clk = 1'b0;
  logic rst;

  logic               en0, load0, en1, load1;
  logic [31:0]        inc0, ofs0, inc1, ofs1;
  logic signed [15:0] sin0, cos0, sin1, cos1;
  logic               valid0, wrap0, valid1, wrap1;
  logic [1:0]         qs0, qs1;

  dds_iq #(.SYNC_UPDATE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .phaseInc(inc0), .inc_load(load0), .phaseOfs(ofs0),
    .sin(sin0), .cos(cos0), .valid(valid0), .wrap(wrap0), .quadSampleState(qs0)
  );

  dds_iq #(.SYNC_UPDATE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .phaseInc(inc1), .inc_load(load1), .phaseOfs(ofs1),
    .sin(sin1), .cos(cos1), .valid(valid1), .wrap(wrap1), .quadSampleState(qs1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                 due;
    logic signed [15:0] s;
    logic signed [15:0] c;
    logic [1:0]         q;
    logic               w;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic signed [15:0] last_s [2];
  logic signed [15:0] last_c [2];
  logic [31:0]        acc_m  [2];
  logic [31:0]        inc_m  [2];
  logic [31:0]        pend_m [2];
  bit                 pend_v [2];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // round((2^15-1) * sin(pi/2 * (i+0.5) / 2048)); e.g. entry 0 = 13, entry 2047 = 32767
  function automatic logic signed [15:0] ref_lut(input logic [10:0] i);
    real v;
    v = 32767.0 * $sin(3.141592653589793 * (real'(i) + 0.5) / 4096.0);
    return 16'($rtoi(v + 0.5));
  endfunction

  function automatic logic signed [15:0] quad_sample(input logic [1:0] x, input logic [10:0] a);
    case (x)
      2'd0:    return ref_lut(a);
      2'd1:    return ref_lut(~a);
      2'd2:    return -ref_lut(a);
      default: return -ref_lut(~a);
    endcase
  endfunction

  // Expected behaviour of one edge; phaseOfs must stay constant over consecutive enabled steps.
  task automatic model_edge(input int id, input bit e, input bit ld, input logic [31:0] inc,
                            input logic [31:0] ofs);
    logic [32:0] sum;
    logic [31:0] p;
    logic        c;
    exp_t        x;
    sum = {1'b0, acc_m[id]} + {1'b0, inc_m[id]};
    c   = e & sum[32];
    if (e) begin
      acc_m[id] = sum[31:0];
      p     = acc_m[id] + ofs;
      x.due = cyc + 2;
      x.q   = p[31:30];
      x.s   = quad_sample(p[31:30], p[29:19]);
      x.c   = quad_sample(p[31:30] + 2'd1, p[29:19]);
      x.w   = c;
      if (id == 0) exp_q0.push_back(x);
      else         exp_q1.push_back(x);
    end
    if (id == 0) begin
      if (ld) inc_m[id] = inc;
    end else begin
      if (pend_v[id] && (c || inc_m[id] == 32'd0)) begin
        inc_m[id]  = pend_m[id];
        pend_v[id] = 1'b0;
      end
      if (ld) begin
        pend_m[id] = inc;
        pend_v[id] = 1'b1;
      end
    end
  endtask

  task automatic step(input int id, input bit e, input bit ld, input logic [31:0] inc,
                      input logic [31:0] ofs);
    if (id == 0) begin
      en0 = e; load0 = ld; inc0 = inc; ofs0 = ofs; en1 = 1'b0; load1 = 1'b0;
    end else begin
      en1 = e; load1 = ld; inc1 = inc; ofs1 = ofs; en0 = 1'b0; load0 = 1'b0;
    end
    @(posedge clk); #1;
    model_edge(0, en0, load0, inc0, ofs0);
    model_edge(1, en1, load1, inc1, ofs1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    en0 = 1'b0; load0 = 1'b0; en1 = 1'b0; load1 = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      exp_q0.delete();
      exp_q1.delete();
      for (int d = 0; d < 2; d++) begin
        acc_m[d] = '0; inc_m[d] = '0; pend_m[d] = '0; pend_v[d] = 1'b0;
        last_s[d] = '0; last_c[d] = '0;
      end
      check("rst valid0", valid0, 0);
      check("rst sin0", sin0, 0);
      check("rst cos0", cos0, 0);
      check("rst wrap0", wrap0, 0);
      check("rst quad0", qs0, 0);
      check("rst valid1", valid1, 0);
      check("rst sin1", sin1, 0);
      check("rst wrap1", wrap1, 0);
    end
    mon_en = 1'b1;
    rst    = 1'b0;
  endtask

  task automatic monitor(input int id, input logic v, input logic signed [15:0] s,
                         input logic signed [15:0] c, input logic [1:0] qq, input logic w);
    exp_t e;
    int   n;
    n = (id == 0) ? exp_q0.size() : exp_q1.size();
    if (v) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected sample at cycle %0d: sin %0d cos %0d, expected none",
                 id, cyc, s, c);
      end else begin
        if (id == 0) e = exp_q0.pop_front();
        else         e = exp_q1.pop_front();
        check($sformatf("dut%0d latency", id), cyc, e.due);
        check($sformatf("dut%0d sin", id), s, e.s);
        check($sformatf("dut%0d cos", id), c, e.c);
        check($sformatf("dut%0d quad", id), qq, e.q);
        check($sformatf("dut%0d wrap", id), w, e.w);
        last_s[id] = e.s;
        last_c[id] = e.c;
      end
    end else begin
      check($sformatf("dut%0d idle wrap", id), w, 0);
      check($sformatf("dut%0d hold sin", id), s, last_s[id]);
      check($sformatf("dut%0d hold cos", id), c, last_c[id]);
      if (n != 0) begin
        if (id == 0) e = exp_q0[0];
        else         e = exp_q1[0];
        if (e.due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL dut%0d missing sample at cycle %0d: valid 0, expected sin %0d due %0d",
                   id, cyc, e.s, e.due);
          if (id == 0) void'(exp_q0.pop_front());
          else         void'(exp_q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor(0, valid0, sin0, cos0, qs0, wrap0);
      monitor(1, valid1, sin1, cos1, qs1, wrap1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en0 = 1'b0; load0 = 1'b0; inc0 = '0; ofs0 = '0;
    en1 = 1'b0; load1 = 1'b0; inc1 = '0; ofs1 = '0;

    // reset, then constant phase 0 (sin=+13, cos=+32767, quadrant 0)
    do_reset(3);
    repeat (4) step(0, 1'b1, 1'b0, 32'd0, 32'd0);

    // quadrant walk with 2^30 steps, immediate update
    step(0, 1'b1, 1'b1, 32'h4000_0000, 32'd0);
    repeat (10) step(0, 1'b1, 1'b0, 32'd0, 32'd0);
    repeat (3) step(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // enable gating 1010...
    for (int k = 0; k < 8; k++) step(0, (k % 2) == 0, 1'b0, 32'd0, 32'd0);
    repeat (3) step(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // reset mid-run, then stationary output at phase 0
    repeat (3) step(0, 1'b1, 1'b0, 32'd0, 32'd0);
    do_reset(1);
    repeat (3) step(0, 1'b1, 1'b0, 32'd0, 32'd0);

    // offset 2^31 (sin=-13, cos=-32767, quadrant 2)
    do_reset(1);
    repeat (4) step(0, 1'b1, 1'b0, 32'd0, 32'h8000_0000);
    repeat (3) step(0, 1'b0, 1'b0, 32'd0, 32'h8000_0000);

    // wrap-synchronous update: 2^28, then 2^29 loaded mid-revolution
    do_reset(1);
    step(1, 1'b1, 1'b1, 32'h1000_0000, 32'd0);
    repeat (6) step(1, 1'b1, 1'b0, 32'd0, 32'd0);
    step(1, 1'b1, 1'b1, 32'h2000_0000, 32'd0);
    repeat (16) step(1, 1'b1, 1'b0, 32'd0, 32'd0);

    // pending word dropped by reset: accumulator stays at 0 afterwards
    step(1, 1'b1, 1'b1, 32'h4000_0000, 32'd0);
    step(1, 1'b1, 1'b0, 32'd0, 32'd0);
    do_reset(1);
    repeat (5) step(1, 1'b1, 1'b0, 32'd0, 32'd0);
    repeat (4) step(1, 1'b0, 1'b0, 32'd0, 32'd0);

    check("dut0 outstanding samples", exp_q0.size(), 0);
    check("dut1 outstanding samples", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
